// File: rtl/bitserial_logic_core.sv
// rtl/bitserial_logic_core.sv - bit-serial logic engine: two shift registers, 1-bit function slice, router
module bitserial_logic_core #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             LoadA,
    input  logic             LoadB,
    input  logic             Execute,
    input  logic [WIDTH-1:0] Din,
    input  logic [2:0]       F,
    input  logic [1:0]       R,
    input  logic [CW-1:0]    Nshift,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [1:0]       State
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_SHIFT = 2'b01;
    localparam logic [1:0] S_HOLD  = 2'b10;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    f_cap;
    logic [1:0]    r_cap;
    logic          f_bit;
    logic          new_a;
    logic          new_b;
    logic [CW-1:0] n_eff;

    always_comb begin
        f_bit = 1'b0;
        case (f_cap)
            3'b000: f_bit = A[0] & B[0];
            3'b001: f_bit = A[0] | B[0];
            3'b010: f_bit = A[0] ^ B[0];
            3'b011: f_bit = 1'b1;
            3'b100: f_bit = ~(A[0] & B[0]);
            3'b101: f_bit = ~(A[0] | B[0]);
            3'b110: f_bit = ~(A[0] ^ B[0]);
            default: f_bit = 1'b0;
        endcase
        new_a = A[0];
        new_b = B[0];
        case (r_cap)
            2'b00: begin new_a = A[0];  new_b = B[0];  end
            2'b01: begin new_a = A[0];  new_b = f_bit; end
            2'b10: begin new_a = f_bit; new_b = B[0];  end
            default: begin new_a = B[0]; new_b = A[0]; end
        endcase
    end

    // Out-of-range counts (0 or above WIDTH) collapse to a full-width run.
    assign n_eff = (Nshift == '0 || Nshift > CW'(WIDTH)) ? CW'(WIDTH) : Nshift;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_IDLE;
            A     <= '0;
            B     <= '0;
            cnt   <= '0;
            f_cap <= '0;
            r_cap <= '0;
            Done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    Done <= 1'b0;
                    if (Execute) begin
                        f_cap <= F;
                        r_cap <= R;
                        cnt   <= n_eff;
                        state <= S_SHIFT;
                    end else begin
                        if (LoadA) A <= Din;
                        if (LoadB) B <= Din;
                    end
                end
                S_SHIFT: begin
                    A   <= {new_a, A[WIDTH-1:1]};
                    B   <= {new_b, B[WIDTH-1:1]};
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= S_HOLD;
                        Done  <= 1'b1;
                    end
                end
                S_HOLD: begin
                    Done <= 1'b0;
                    // Waiting for Execute to drop gives one run per press.
                    if (!Execute) state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy  = (state != S_IDLE);
    assign State = state;

endmodule
